// File: rtl/pulse_train_pkg.sv
// Shared definitions for the pulse train generator: channel state encoding
// and default parameter values used by the top and the per-channel engine.
package pulse_train_pkg;

    localparam int unsigned DEF_CHANNELS  = 4;
    localparam int unsigned DEF_CNT_WIDTH = 16;
    localparam int unsigned DEF_REP_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HIGH = 2'd1,
        ST_LOW  = 2'd2
    } chan_state_t;

endpackage

// File: rtl/pulse_train_chan.sv
// Single pulse-train channel: IDLE/HIGH/LOW state machine with latched
// high/low lengths and a repeat counter (0 = run until stopped).
module pulse_train_chan
    import pulse_train_pkg::*;
#(
    parameter int p_CNT_WIDTH = DEF_CNT_WIDTH,
    parameter int p_REP_WIDTH = DEF_REP_WIDTH
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_go,
    input  logic                   i_stop,
    input  logic                   i_retrig,
    input  logic [p_CNT_WIDTH-1:0] i_high_len,
    input  logic [p_CNT_WIDTH-1:0] i_low_len,
    input  logic [p_REP_WIDTH-1:0] i_repeat,
    output logic                   o_pulse,
    output logic                   o_busy,
    output logic                   o_done
);

    // A programmed length of zero still produces a one-cycle phase.
    function automatic logic [p_CNT_WIDTH-1:0] sat_len(input logic [p_CNT_WIDTH-1:0] len);
        logic [p_CNT_WIDTH-1:0] one;
        one    = '0;
        one[0] = 1'b1;
        return (len == '0) ? one : len;
    endfunction

    chan_state_t            state_q, state_d;
    logic [p_CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [p_REP_WIDTH-1:0] rep_q, rep_d;
    logic [p_CNT_WIDTH-1:0] high_q, high_d;
    logic [p_CNT_WIDTH-1:0] low_q, low_d;
    logic                   cont_q, cont_d;
    logic                   pulse_q, pulse_d;
    logic                   done_q, done_d;

    logic go_ok;
    logic phase_last;
    logic train_last;

    // A go is accepted from IDLE, or while busy only with retrigger enabled;
    // a simultaneous stop always discards it. Counters never wrap below 1.
    always_comb begin
        go_ok      = i_go && !i_stop && ((state_q == ST_IDLE) || i_retrig);
        phase_last = (cnt_q <= {{(p_CNT_WIDTH-1){1'b0}}, 1'b1});
        train_last = !cont_q && (rep_q <= {{(p_REP_WIDTH-1){1'b0}}, 1'b1});
    end

    // Next-state logic: stop has top priority, then go/retrigger, then phase sequencing.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rep_d   = rep_q;
        high_d  = high_q;
        low_d   = low_q;
        cont_d  = cont_q;
        pulse_d = pulse_q;
        done_d  = 1'b0;

        if ((state_q != ST_IDLE) && i_stop) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            rep_d   = '0;
            pulse_d = 1'b0;
        end else if (go_ok) begin
            high_d  = sat_len(i_high_len);
            low_d   = sat_len(i_low_len);
            rep_d   = i_repeat;
            cont_d  = (i_repeat == '0);
            cnt_d   = sat_len(i_high_len);
            state_d = ST_HIGH;
            pulse_d = 1'b1;
        end else begin
            case (state_q)
                ST_HIGH: begin
                    if (phase_last) begin
                        if (train_last) begin
                            state_d = ST_IDLE;
                            cnt_d   = '0;
                            rep_d   = '0;
                            pulse_d = 1'b0;
                            done_d  = 1'b1;
                        end else begin
                            state_d = ST_LOW;
                            cnt_d   = low_q;
                            pulse_d = 1'b0;
                            if (!cont_q) begin
                                rep_d = rep_q - 1'b1;
                            end
                        end
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                ST_LOW: begin
                    if (phase_last) begin
                        state_d = ST_HIGH;
                        cnt_d   = high_q;
                        pulse_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    pulse_d = 1'b0;
                end
            endcase
        end
    end

    // State and datapath registers; reset clears everything immediately.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            rep_q   <= '0;
            high_q  <= '0;
            low_q   <= '0;
            cont_q  <= 1'b0;
            pulse_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rep_q   <= rep_d;
            high_q  <= high_d;
            low_q   <= low_d;
            cont_q  <= cont_d;
            pulse_q <= pulse_d;
            done_q  <= done_d;
        end
    end

    assign o_pulse = pulse_q;
    assign o_busy  = (state_q != ST_IDLE);
    assign o_done  = done_q;

endmodule

// File: rtl/pulse_train_gen.sv
// Multi-channel pulse train generator: one independent pulse_train_chan per
// channel, with the packed config buses sliced per channel.
module pulse_train_gen
    import pulse_train_pkg::*;
#(
    parameter int p_CHANNELS  = DEF_CHANNELS,
    parameter int p_CNT_WIDTH = DEF_CNT_WIDTH,
    parameter int p_REP_WIDTH = DEF_REP_WIDTH
) (
    input  logic                              i_clk,
    input  logic                              i_rst_n,
    input  logic [p_CHANNELS-1:0]             i_go,
    input  logic [p_CHANNELS-1:0]             i_stop,
    input  logic [p_CHANNELS-1:0]             i_retrig,
    input  logic [p_CHANNELS*p_CNT_WIDTH-1:0] i_high_len,
    input  logic [p_CHANNELS*p_CNT_WIDTH-1:0] i_low_len,
    input  logic [p_CHANNELS*p_REP_WIDTH-1:0] i_repeat,
    output logic [p_CHANNELS-1:0]             o_pulse,
    output logic [p_CHANNELS-1:0]             o_busy,
    output logic [p_CHANNELS-1:0]             o_done
);

    for (genvar g = 0; g < p_CHANNELS; g++) begin : g_chan
        pulse_train_chan #(
            .p_CNT_WIDTH (p_CNT_WIDTH),
            .p_REP_WIDTH (p_REP_WIDTH)
        ) u_chan (
            .i_clk      (i_clk),
            .i_rst_n    (i_rst_n),
            .i_go       (i_go[g]),
            .i_stop     (i_stop[g]),
            .i_retrig   (i_retrig[g]),
            .i_high_len (i_high_len[g*p_CNT_WIDTH +: p_CNT_WIDTH]),
            .i_low_len  (i_low_len[g*p_CNT_WIDTH +: p_CNT_WIDTH]),
            .i_repeat   (i_repeat[g*p_REP_WIDTH +: p_REP_WIDTH]),
            .o_pulse    (o_pulse[g]),
            .o_busy     (o_busy[g]),
            .o_done     (o_done[g])
        );
    end

endmodule

// File: doc/pulse_train_gen.md
PULSE_TRAIN_GEN -- requirements
Module: pulse_train_gen

Interface
REQ-001 The block SHALL have parameter p_CHANNELS, default 4, number of independent pulse channels (legal 1..16).
REQ-002 The block SHALL have parameter p_CNT_WIDTH, default 16, width of the high/low length fields.
REQ-003 The block SHALL have parameter p_REP_WIDTH, default 8, width of the repeat-count field.
REQ-004 The block SHALL have port i_clk  input  1  sole clock; all logic on its rising edge.
REQ-005 The block SHALL have port i_rst_n  input  1  asynchronous, active-low reset.
REQ-006 The block SHALL have port i_go  input  p_CHANNELS  per-channel start strobe.
REQ-007 The block SHALL have port i_stop  input  p_CHANNELS  per-channel abort strobe.
REQ-008 The block SHALL have port i_retrig  input  p_CHANNELS  per-channel retrigger enable.
REQ-009 The block SHALL have port i_high_len  input  p_CHANNELS*p_CNT_WIDTH  per-channel high-phase length in cycles; channel n uses slice [n*p_CNT_WIDTH +: p_CNT_WIDTH].
REQ-010 The block SHALL have port i_low_len  input  p_CHANNELS*p_CNT_WIDTH  per-channel low-phase length in cycles; same slicing.
REQ-011 The block SHALL have port i_repeat  input  p_CHANNELS*p_REP_WIDTH  per-channel pulse count; 0 means continuous.
REQ-012 The block SHALL have port o_pulse  output  p_CHANNELS  registered pulse outputs.
REQ-013 The block SHALL have port o_busy  output  p_CHANNELS  high while the channel is not IDLE.
REQ-014 The block SHALL have port o_done  output  p_CHANNELS  one-cycle strobe on natural completion.

Function
REQ-015 Each channel SHALL run a state machine with states IDLE, HIGH, and LOW, and SHALL be independent of all other channels.
REQ-016 In IDLE, i_go=1 sampled at edge k SHALL latch the high length, low length, and repeat count for that channel, and SHALL enter HIGH; o_pulse SHALL be 1 from edge k to edge k+H, where H is the latched high length.
REQ-017 A latched length of 0 SHALL be treated as 1; the arithmetic SHALL be unsigned down-counters of p_CNT_WIDTH bits with no wrap-around.
REQ-018 When HIGH ends and pulses remain (or the repeat count is 0), the channel SHALL enter LOW with o_pulse=0 for L cycles, then re-enter HIGH.
REQ-019 When the last HIGH phase of a finite train ends, the channel SHALL go to IDLE with no trailing LOW phase, and o_done SHALL be 1 for exactly that one cycle, coincident with o_pulse falling.
REQ-020 i_stop=1 in HIGH or LOW SHALL force IDLE at the next edge, with o_pulse=0 and o_busy=0 from that edge; o_done SHALL NOT assert.
REQ-021 If i_stop and i_go are both 1 in the same cycle, i_stop SHALL win in every state, and the go SHALL be discarded.
REQ-022 If i_go=1 while busy and i_retrig=0, the go SHALL be ignored.
REQ-023 If i_go=1 while busy and i_retrig=1, the channel SHALL relatch its config, restart HIGH with a full count, and reload the repeat count; o_pulse SHALL stay 1 with no glitch when already HIGH.
REQ-024 Config inputs SHALL be sampled only on an accepted go; changes while busy SHALL have no effect.
REQ-025 i_stop in IDLE SHALL have no effect.
REQ-026 o_busy SHALL be 1 from the edge accepting go until the edge returning to IDLE.

Reset
REQ-027 While i_rst_n=0, every channel SHALL be in IDLE with o_pulse=0, o_busy=0, o_done=0, and all counters at 0, asynchronously.
REQ-028 Assertion of reset mid-train SHALL abort immediately with no o_done; after deassertion, the first go SHALL be accepted at the first rising edge.

Structure
REQ-029 A shared package pulse_train_pkg SHALL hold the state enum (IDLE, HIGH, LOW) and the default width constants.
REQ-030 The single-channel logic SHALL be a sub-module pulse_train_chan, replicated p_CHANNELS times by a generate loop in pulse_train_gen.

Verification
REQ-031 Scenario: channel 0 with H=5, repeat=1, go for 1 cycle -> o_pulse high for exactly 5 cycles, o_done 1 for one cycle at the fall, o_busy low afterwards.
REQ-032 Scenario: H=5, go, then stop 2 cycles after the go cycle -> o_pulse high for 2 cycles (range 1..3 accepted), no o_done.
REQ-033 Scenario: H=3, L=2, repeat=3 -> pattern 111 00 111 00 111, then IDLE, with one o_done.
REQ-034 Scenario: repeat=0, H=2, L=2 -> continuous 1100 pattern for 50+ cycles until stop; stop+go in the same cycle -> IDLE.
REQ-035 Scenario: H=6, go at t, retrig=1, go again at t+3 -> o_pulse high continuously for 9 cycles; with retrig=0 -> high for 6 cycles.
REQ-036 Scenario: 4 channels started on staggered cycles with H=0 and reset asserted mid-train -> H=0 gives a 1-cycle pulse, channels run without interaction, and all outputs go to 0 immediately on reset.
